// File: rtl/intdiv_pkg.sv
// Shared definitions for the integer-division block family: signed-digit (sd2)
// encodings, the reconstruction FSM state encodings and common flag constants.
package intdiv_pkg;

    // Radix-2 signed-digit encodings used by the divider datapaths.
    typedef enum logic [1:0] {
        Sd2Zero = 2'b00,
        Sd2Pos  = 2'b01,
        Sd2Neg  = 2'b11
    } sd2_e;

    // Reconstruction FSM states.
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StMul  = 2'b01,
        StDone = 2'b10
    } state_e;

    localparam logic On       = 1'b1;
    localparam logic Off      = 1'b0;
    localparam logic Positive = 1'b0;
    localparam logic Negative = 1'b1;

endpackage

// File: rtl/intdiv_addsub.sv
// Width-parameterised adder/subtractor: sum = sub ? a - b : a + b.
module intdiv_addsub #(
    parameter int unsigned Width = 9
) (
    input  logic [Width-1:0] a,
    input  logic [Width-1:0] b,
    input  logic             sub,
    output logic [Width-1:0] sum
);

    // Single carry chain; subtraction via inverted operand and carry-in.
    always_comb begin
        sum = a + (sub ? ~b : b) + {{(Width-1){1'b0}}, sub};
    end

endmodule

// File: rtl/intdiv_recon.sv
// Dividend reconstruction x = z*y + r by serial shift-and-add over the bits
// of z, LSB first, with a 2N+1-bit accumulator so no intermediate step wraps.
// Optional remainder-consistency checker (err port) built only when
// INTDIV_RECON_CHECK_EN is defined.
module intdiv_recon
    import intdiv_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   z,
    input  logic [N-1:0]   y,
    input  logic [N-1:0]   r,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] x,
    output logic           ovf
`ifdef INTDIV_RECON_CHECK_EN
    ,
    output logic           err
`endif
);

    localparam int unsigned AccW = 2 * N + 1;
    localparam int unsigned CntW = $clog2(N);
    localparam logic [CntW-1:0] LastBit = CntW'(N - 1);

    state_e          state_q;
    logic [N-1:0]    z_q;
    logic [N-1:0]    y_q;
    logic [AccW-1:0] acc_q;
    logic [CntW-1:0] cnt_q;
    logic            ovf_q;

    logic [AccW-1:0] addend;
    logic            sub_sel;
    logic [AccW-1:0] acc_sum;
    logic            fits_n;
    logic            err_n;

    // Partial product for the current bit of z; the sign bit carries weight -2^(N-1).
    always_comb begin
        addend  = z_q[cnt_q] ? ({{(N + 1){y_q[N-1]}}, y_q} << cnt_q) : '0;
        sub_sel = (cnt_q == LastBit);
    end

    intdiv_addsub #(
        .Width(AccW)
    ) u_addsub (
        .a  (acc_q),
        .b  (addend),
        .sub(sub_sel),
        .sum(acc_sum)
    );

    // Final result fits N signed bits iff bits [2N-1:N-1] are all copies of the sign.
    always_comb begin
        fits_n = (acc_sum[2*N-1:N-1] == {(N + 1){acc_sum[N-1]}});
    end

`ifdef INTDIV_RECON_CHECK_EN
    logic [N-1:0] r_q;
    logic         err_q;
    logic [N:0]   r_ext;
    logic [N:0]   y_ext;
    logic [N:0]   r_mag;
    logic [N:0]   y_mag;

    // Magnitudes are one bit wider so -2^(N-1) negates exactly.
    always_comb begin
        r_ext = {r_q[N-1], r_q};
        y_ext = {y_q[N-1], y_q};
        r_mag = (r_q[N-1] == Negative) ? (~r_ext + 1'b1) : r_ext;
        y_mag = (y_q[N-1] == Negative) ? (~y_ext + 1'b1) : y_ext;
        err_n = ((y_q != '0) && (r_mag >= y_mag)) ||
                ((r_q != '0) && (r_q[N-1] != acc_sum[2*N-1]));
    end

    // Checker operand capture and registered flag, updated on entry to DONE.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_q   <= '0;
            err_q <= Off;
        end else if (state_q == StIdle && in_valid) begin
            r_q <= r;
        end else if (state_q == StMul && cnt_q == LastBit) begin
            err_q <= err_n;
        end
    end

    assign err = err_q;
`else
    assign err_n = Off;
    logic unused_err_n;
    assign unused_err_n = err_n;
`endif

    // FSM, bit counter and accumulator.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            z_q     <= '0;
            y_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= Off;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        z_q     <= z;
                        y_q     <= y;
                        acc_q   <= {{(N + 1){r[N-1]}}, r};
                        cnt_q   <= '0;
                        state_q <= StMul;
                    end
                end
                StMul: begin
                    acc_q <= acc_sum;
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q == LastBit) begin
                        ovf_q   <= fits_n ? Off : On;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // The accumulator MSB only guards against wrap; x is its low 2N bits.
    logic unused_acc_msb;
    assign unused_acc_msb = acc_q[AccW-1];

    assign in_ready  = (state_q == StIdle) ? On : Off;
    assign out_valid = (state_q == StDone) ? On : Off;
    assign x         = acc_q[2*N-1:0];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_intdiv_recon.sv
// Self-checking bench for intdiv_recon (N=4). Expected results are computed
// from integer arithmetic and queued at acceptance, then popped at output.
// Build with INTDIV_RECON_CHECK_EN defined to exercise the err checker too.
module tb_intdiv_recon;

    localparam int N = 4;
    localparam int W = 2 * N;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [N-1:0] z = '0;
    logic [N-1:0] y = '0;
    logic [N-1:0] r = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] x;
    logic         ovf;
`ifdef INTDIV_RECON_CHECK_EN
    logic         err;
`endif

    always #5 clock = ~clock;

    intdiv_recon #(
        .N(N)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .z        (z),
        .y        (y),
        .r        (r),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .x        (x),
        .ovf      (ovf)
`ifdef INTDIV_RECON_CHECK_EN
        ,
        .err      (err)
`endif
    );

    typedef struct packed {
        logic [W-1:0] x;
        logic         ovf;
        logic         err;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   passed = 0;

    function automatic int absi(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic exp_t model(input logic [N-1:0] zb, input logic [N-1:0] yb,
                                   input logic [N-1:0] rb);
        exp_t e;
        int zi, yi, ri, xi;
        zi    = int'($signed(zb));
        yi    = int'($signed(yb));
        ri    = int'($signed(rb));
        xi    = zi * yi + ri;
        e.x   = W'(xi);
        e.ovf = (xi < -(1 << (N - 1))) || (xi > (1 << (N - 1)) - 1);
        e.err = ((yi != 0) && (absi(ri) >= absi(yi))) || ((ri != 0) && ((ri < 0) != (xi < 0)));
        return e;
    endfunction

    // Drive one operand set until accepted; returns #1 after the acceptance edge.
    task automatic send(input logic [N-1:0] zv, input logic [N-1:0] yv, input logic [N-1:0] rv);
        for (int i = 0; i < 50 && !in_ready; i++) begin
            @(posedge clock);
            #1;
        end
        in_valid = 1'b1;
        z = zv;
        y = yv;
        r = rv;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        sb.push_back(model(zv, yv, rv));
    endtask

    // Bounded wait for out_valid; cyc counts edges since the call.
    task automatic wait_out(output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clock);
            #1;
            cyc++;
        end
    endtask

    task automatic retire();
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", in_ready);
        else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", out_valid);
        else passed++;
        total++; if (x !== '0) $display("FAIL reset_x got=%0d want=0", x);
        else passed++;
        total++; if (ovf !== 1'b0) $display("FAIL reset_ovf got=%b want=0", ovf);
        else passed++;
`ifdef INTDIV_RECON_CHECK_EN
        total++; if (err !== 1'b0) $display("FAIL reset_err got=%b want=0", err);
        else passed++;
`endif
        reset = 1'b0;
    endtask

    // Fixed vectors: basic, negative operands, most-negative corner and y=0.
    task automatic test_vectors();
        logic [3*N-1:0] vec[5];
        int cyc;
        bit ok;
        exp_t e;
        vec[0] = {4'd2, 4'd3, 4'd1};
        vec[1] = {4'hD, 4'd4, 4'hF};  // -3, 4, -1
        vec[2] = {4'hC, 4'd2, 4'hF};  // -4, 2, -1
        vec[3] = {4'h8, 4'h8, 4'd0};  // -8, -8, 0
        vec[4] = {4'd5, 4'd0, 4'h9};  // 5, 0, -7
        for (int i = 0; i < 5; i++) begin
            send(vec[i][11:8], vec[i][7:4], vec[i][3:0]);
            wait_out(cyc, ok);
            e = sb.pop_front();
            total++; if (!ok || cyc != N) $display("FAIL vec%0d_latency got=%0d want=%0d", i, cyc, N);
            else passed++;
            total++; if (x !== e.x) $display("FAIL vec%0d_x got=%0d want=%0d", i,
                                             $signed(x), $signed(e.x));
            else passed++;
            total++; if (ovf !== e.ovf) $display("FAIL vec%0d_ovf got=%b want=%b", i, ovf, e.ovf);
            else passed++;
`ifdef INTDIV_RECON_CHECK_EN
            total++; if (err !== e.err) $display("FAIL vec%0d_err got=%b want=%b", i, err, e.err);
            else passed++;
`endif
            retire();
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        bit ok;
        exp_t e;
        send(4'd3, 4'd2, 4'd1);
        wait_out(cyc, ok);
        e = sb.pop_front();
        total++; if (!ok) $display("FAIL bp_timeout got=0 want=1");
        else passed++;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;  // must be ignored outside IDLE
            total++; if (x !== e.x || out_valid !== 1'b1 || in_ready !== 1'b0)
                $display("FAIL bp_hold%0d got x=%0d ov=%b ir=%b want x=%0d ov=1 ir=0", i,
                         $signed(x), out_valid, in_ready, $signed(e.x));
            else passed++;
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        retire();
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL bp_release got ir=%b ov=%b want ir=1 ov=0", in_ready, out_valid);
        else passed++;
        send(4'd1, 4'd1, 4'd0);
        wait_out(cyc, ok);
        e = sb.pop_front();
        total++; if (!ok || x !== e.x) $display("FAIL bp_second_x got=%0d want=%0d",
                                                $signed(x), $signed(e.x));
        else passed++;
        retire();
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit ok;
        exp_t e;
        send(4'd7, 4'd7, 4'd3);
        void'(sb.pop_back());  // abandoned by reset
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || x !== '0)
            $display("FAIL midreset got ov=%b ir=%b x=%0d want ov=0 ir=1 x=0",
                     out_valid, in_ready, x);
        else passed++;
        reset = 1'b0;
        send(4'hE, 4'd3, 4'hF);  // -2, 3, -1
        wait_out(cyc, ok);
        e = sb.pop_front();
        total++; if (!ok || cyc != N || x !== e.x || ovf !== e.ovf)
            $display("FAIL midreset_next got x=%0d ovf=%b cyc=%0d want x=%0d ovf=%b cyc=%0d",
                     $signed(x), ovf, cyc, $signed(e.x), e.ovf, N);
        else passed++;
        retire();
    endtask

    // Random operands with junk on in_valid/out_ready during MUL, minimal gap.
    task automatic test_back_to_back();
        int cyc;
        bit ok;
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            send(N'($urandom), N'($urandom), N'($urandom));
            in_valid  = 1'b1;
            z         = N'($urandom);
            y         = N'($urandom);
            r         = N'($urandom);
            out_ready = 1'b1;
            wait_out(cyc, ok);
            in_valid = 1'b0;
            e = sb.pop_front();
            total++; if (!ok || cyc != N || x !== e.x || ovf !== e.ovf)
                $display("FAIL b2b%0d got x=%0d ovf=%b cyc=%0d want x=%0d ovf=%b cyc=%0d", i,
                         $signed(x), ovf, cyc, $signed(e.x), e.ovf, N);
            else passed++;
`ifdef INTDIV_RECON_CHECK_EN
            total++; if (err !== e.err) $display("FAIL b2b%0d_err got=%b want=%b", i, err, e.err);
            else passed++;
`endif
            @(posedge clock);
            #1;
            out_ready = 1'b0;
            total++; if (in_ready !== 1'b1) $display("FAIL b2b%0d_idle got=%b want=1", i, in_ready);
            else passed++;
        end
    endtask

`ifdef INTDIV_RECON_CHECK_EN
    task automatic test_err();
        logic [3*N-1:0] vec[3];
        logic           want[3];
        int cyc;
        bit ok;
        vec[0] = {4'd1, 4'd3, 4'd3};
        vec[1] = {4'hF, 4'd3, 4'd1};
        vec[2] = {4'd2, 4'd3, 4'd1};
        want[0] = 1'b1;
        want[1] = 1'b1;
        want[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(vec[i][11:8], vec[i][7:4], vec[i][3:0]);
            void'(sb.pop_front());
            wait_out(cyc, ok);
            total++; if (!ok || err !== want[i])
                $display("FAIL err_case%0d got=%b want=%b", i, err, want[i]);
            else passed++;
            retire();
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
`ifdef INTDIV_RECON_CHECK_EN
        test_err();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/intdiv_recon.md
INTDIV_RECON -- requirements
Module: intdiv_recon

Interface
REQ-001 Parameter N, default 4, signed operand width in bits; legal for N >= 2.
REQ-002 clock  input  1  rising-edge clock; the only clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  z, y and r are valid this cycle.
REQ-005 in_ready  output  1  block can accept an operand set.
REQ-006 z  input  N  signed quotient, two's complement.
REQ-007 y  input  N  signed divisor, two's complement.
REQ-008 r  input  N  signed remainder, two's complement.
REQ-009 out_valid  output  1  x and ovf are valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 x  output  2N  signed reconstructed dividend, x = z*y + r.
REQ-012 ovf  output  1  x does not fit in N signed bits.
REQ-013 err  output  1  remainder inconsistent; present only when INTDIV_RECON_CHECK_EN is defined.

Function
REQ-014 The block SHALL have exactly three states: IDLE, MUL and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-016 Acceptance SHALL occur on a rising edge with in_valid=1 and in_ready=1.
REQ-017 On acceptance, the block SHALL latch z and y, set the 2N+1-bit accumulator to sign-extended r, clear the bit counter, and enter MUL.
REQ-018 Each MUL cycle SHALL examine one bit of z, LSB first; for a set bit it SHALL add y, sign-extended and shifted left by the bit index, to the accumulator.
REQ-019 For bit N-1 (the sign bit) the shifted y SHALL be subtracted rather than added.
REQ-020 After exactly N MUL cycles the block SHALL enter DONE, so out_valid rises N cycles after the acceptance edge.
REQ-021 x SHALL equal the low 2N bits of the accumulator; the arithmetic SHALL be exact for all inputs, including z = y = -2^(N-1).
REQ-022 ovf SHALL be 1 iff x is less than -2^(N-1) or greater than 2^(N-1)-1.
REQ-023 In DONE, x, ovf and err SHALL hold stable until an edge with out_ready=1.
REQ-024 On that edge the block SHALL move to IDLE; no new operands are accepted on that same edge, so the minimum initiation interval is N+2 cycles.
REQ-025 in_valid SHALL be ignored outside IDLE, and out_ready SHALL be ignored outside DONE.
REQ-026 y = 0 SHALL NOT be treated specially; the result is r.

Reset
REQ-027 On a reset edge the block SHALL enter IDLE with in_ready=1, out_valid=0, x=0, ovf=0 and err=0.
REQ-028 Reset SHALL take priority over every other event, and any operation in MUL or DONE SHALL be abandoned without producing output.
REQ-029 On the first edge after reset deasserts, the block SHALL be able to accept operands.

Configuration
REQ-030 The macro INTDIV_RECON_CHECK_EN SHALL control the remainder-consistency checker.
REQ-031 With INTDIV_RECON_CHECK_EN defined, err SHALL be valid with out_valid and SHALL be 1 iff any of the following holds:
- |r| >= |y| with y nonzero;
- r is nonzero and sign(r) differs from sign(x).
REQ-032 The magnitudes for the err check SHALL be computed N+1 bits wide, so -2^(N-1) is handled exactly.
REQ-033 Without INTDIV_RECON_CHECK_EN, the err port and all checker logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-034 The state encodings (IDLE=2'b00, MUL=2'b01, DONE=2'b10) SHALL live in the shared include intdiv_pkg, next to the existing sd2 encoding definitions.
REQ-035 The ON/OFF and POSITIVE/NEGATIVE constants SHALL also live in intdiv_pkg.
REQ-036 The add/subtract datapath SHALL be a single sub-module, intdiv_addsub: parameterised width, inputs a, b and sub, output sum.
REQ-037 The FSM, bit counter and accumulator SHALL stay in intdiv_recon.

Verification
REQ-038 N=4, z=2, y=3, r=1 -> out_valid 4 cycles after acceptance, x=7, ovf=0, err=0.
REQ-039 z=-3, y=4, r=-1 -> x=-13, ovf=1; and z=-4, y=2, r=-1 -> x=-9, ovf=1.
REQ-040 z=-8, y=-8, r=0 -> x=64, ovf=1; no intermediate wrap.
REQ-041 Backpressure: out_ready=0 for 5 cycles in DONE -> x is held and in_ready=0 throughout; out_ready=1 -> IDLE on the next edge; a second operand set (z=1, y=1, r=0) then gives x=1.
REQ-042 Reset asserted 2 cycles into MUL -> next cycle out_valid=0, in_ready=1, x=0; the following operands complete normally.
REQ-043 With INTDIV_RECON_CHECK_EN defined: z=1, y=3, r=3 -> err=1; z=-1, y=3, r=1 -> err=1 (sign mismatch); z=2, y=3, r=1 -> err=0.
